// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared types and constants for the SPI command-frame controller
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_HDR  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam int HDR_WR_BIT   = 7;
    localparam int HDR_LEN_MSB  = 6;
    localparam int HDR_LEN_LSB  = 4;
    localparam int HDR_ADDR_MSB = 3;
    localparam int HDR_ADDR_LSB = 0;

endpackage

// File: rtl/spi_cmd_regfile.sv
// rtl/spi_cmd_regfile.sv - 16x8 register file, one write port, one registered read port
module spi_cmd_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [16];

    // Same-cycle read of a written address returns the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
            end
            rdata <= 8'h00;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - parses SPI write frames and commits checksum-verified payloads
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_rdy,
    output logic       o_rx_ren,
    input  logic [3:0] i_rd_addr,
    output logic [7:0] o_rd_data,
    output logic       o_frame_ok,
    output logic       o_frame_err,
    output logic [1:0] o_err_code,
    output logic [7:0] o_err_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t      state, state_nxt;
    logic [2:0]  len_m1;
    logic [3:0]  base_addr;
    logic [2:0]  idx;
    logic [7:0]  csum;
    logic [7:0]  pay_buf [8];
    logic [TW-1:0] tmo_cnt;

    logic        accept;
    logic        timing;
    logic        tmo_hit;
    logic        err_set;
    logic [1:0]  err_code_nxt;
    logic        ok_set;
    logic        we;
    logic [3:0]  waddr;

    // While o_rx_ren is high the receiver's rdy is stale, so it blocks acceptance.
    assign accept  = i_rx_rdy && !o_rx_ren && (state != COMMIT);
    assign timing  = (state == PAYLOAD) || (state == CHECK);
    assign tmo_hit = timing && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign we      = (state == COMMIT);
    assign waddr   = base_addr + {1'b0, idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        err_set      = 1'b0;
        err_code_nxt = ERR_NONE;
        ok_set       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!i_rx_data[HDR_WR_BIT]) begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_HDR;
                    end else begin
                        state_nxt = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    if (idx == len_m1) begin
                        state_nxt = CHECK;
                    end
                end else if (tmo_hit) begin
                    err_set      = 1'b1;
                    err_code_nxt = ERR_TMO;
                    state_nxt    = IDLE;
                end
            end
            CHECK: begin
                if (accept) begin
                    if (i_rx_data == csum) begin
                        state_nxt = COMMIT;
                    end else begin
                        err_set      = 1'b1;
                        err_code_nxt = ERR_CSUM;
                        state_nxt    = IDLE;
                    end
                end else if (tmo_hit) begin
                    err_set      = 1'b1;
                    err_code_nxt = ERR_TMO;
                    state_nxt    = IDLE;
                end
            end
            COMMIT: begin
                if (idx == len_m1) begin
                    ok_set    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // idx walks the buffer during PAYLOAD and again during COMMIT; it is 0 on COMMIT entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_m1    <= 3'd0;
            base_addr <= 4'd0;
            idx       <= 3'd0;
            csum      <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                pay_buf[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept && i_rx_data[HDR_WR_BIT]) begin
                        len_m1    <= i_rx_data[HDR_LEN_MSB:HDR_LEN_LSB];
                        base_addr <= i_rx_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                        csum      <= i_rx_data;
                        idx       <= 3'd0;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        pay_buf[idx] <= i_rx_data;
                        csum         <= csum ^ i_rx_data;
                        idx          <= (idx == len_m1) ? 3'd0 : idx + 3'd1;
                    end
                end
                COMMIT: begin
                    idx <= idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept || !timing || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rx_ren    <= 1'b0;
            o_frame_ok  <= 1'b0;
            o_frame_err <= 1'b0;
            o_err_code  <= ERR_NONE;
            o_err_cnt   <= 8'h00;
        end else begin
            o_rx_ren    <= accept;
            o_frame_ok  <= ok_set;
            o_frame_err <= err_set;
            if (err_set) begin
                o_err_code <= err_code_nxt;
                if (o_err_cnt != 8'hFF) begin
                    o_err_cnt <= o_err_cnt + 8'd1;
                end
            end
        end
    end

    spi_cmd_regfile u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (waddr),
        .wdata (pay_buf[idx]),
        .raddr (i_rd_addr),
        .rdata (o_rd_data)
    );

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - scoreboard bench for spi_cmd_ctrl
module tb_spi_cmd_ctrl;

    localparam int TMO = 50;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_rdy;
    logic       o_rx_ren;
    logic [3:0] i_rd_addr;
    logic [7:0] o_rd_data;
    logic       o_frame_ok;
    logic       o_frame_err;
    logic [1:0] o_err_code;
    logic [7:0] o_err_cnt;

    spi_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx_data   (i_rx_data),
        .i_rx_rdy    (i_rx_rdy),
        .o_rx_ren    (o_rx_ren),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_frame_ok  (o_frame_ok),
        .o_frame_err (o_frame_err),
        .o_err_code  (o_err_code),
        .o_err_cnt   (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    logic [7:0] tx_q [$];
    logic [7:0] mdl_reg [16];
    logic [7:0] mdl_err_cnt = 8'h00;
    bit         mon_en = 1'b1;
    bit         prev_ren = 1'b0;
    int         ren_pairs = 0;
    int         ren_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Events encoded as 0x80 = frame_ok, 0x01..0x03 = frame_err with that code.
    always @(negedge clk) begin
        if (rst_n && mon_en && (o_frame_ok || o_frame_err)) begin
            logic [7:0] obs;
            logic [7:0] exp;
            obs = o_frame_ok ? 8'h80 : {6'b0, o_err_code};
            if (o_frame_ok && o_frame_err) obs = 8'hFF;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {24'b0, obs}, 32'hEE);
            end else begin
                exp = exp_q.pop_front();
                chk("frame_event", {24'b0, obs}, {24'b0, exp});
                if (exp != 8'h80 && mdl_err_cnt != 8'hFF) mdl_err_cnt = mdl_err_cnt + 8'd1;
                chk("err_cnt_at_event", {24'b0, o_err_cnt}, {24'b0, mdl_err_cnt});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_rx_ren && prev_ren) ren_pairs++;
            if (o_rx_ren) ren_pulses++;
            prev_ren = o_rx_ren;
        end else begin
            prev_ren = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        i_rx_data = b;
        i_rx_rdy  = 1'b1;
        @(negedge clk);
        while (!o_rx_ren && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ren_wait_expired", 32'(n), 0);
        i_rx_rdy = 1'b0;
    endtask

    task automatic send_frame();
        logic [7:0] hdr;
        logic [7:0] x;
        logic [3:0] a;
        int         len;
        hdr = tx_q[0];
        if (!hdr[7]) begin
            exp_q.push_back(8'h01);
            send_byte(hdr);
            return;
        end
        len = int'(hdr[6:4]) + 1;
        x = hdr;
        for (int i = 1; i <= len; i++) x = x ^ tx_q[i];
        if (x == tx_q[len + 1]) begin
            exp_q.push_back(8'h80);
            for (int i = 0; i < len; i++) begin
                a = hdr[3:0] + 4'(i);
                mdl_reg[a] = tx_q[i + 1];
            end
        end else begin
            exp_q.push_back(8'h02);
        end
        for (int i = 0; i < len + 2; i++) send_byte(tx_q[i]);
    endtask

    task automatic wait_events(output int waited);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("event_wait_expired", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        waited = n;
        repeat (2) @(negedge clk);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        i_rd_addr = a;
        @(negedge clk);
        d = o_rd_data;
    endtask

    task automatic verify_regs(input string tag);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            read_reg(4'(i), d);
            chk($sformatf("%s_reg%0d", tag, i), {24'b0, d}, {24'b0, mdl_reg[i]});
        end
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        i_rx_data = 8'h00;
        i_rx_rdy  = 1'b0;
        i_rd_addr = 4'h0;
        for (int i = 0; i < 16; i++) mdl_reg[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ren", {31'b0, o_rx_ren}, 0);
        chk("rst_ok", {31'b0, o_frame_ok}, 0);
        chk("rst_err", {31'b0, o_frame_err}, 0);
        chk("rst_code", {30'b0, o_err_code}, 0);
        chk("rst_cnt", {24'b0, o_err_cnt}, 0);
        rst_n = 1'b1;
        verify_regs("reset");

        tx_q = '{8'h92, 8'hAA, 8'h55, 8'h6D};
        send_frame();
        wait_events(w);
        verify_regs("basic");
        chk("basic_err_cnt", {24'b0, o_err_cnt}, 0);

        tx_q = '{8'hBF, 8'h01, 8'h02, 8'h03, 8'h04, 8'hBB};
        send_frame();
        wait_events(w);
        verify_regs("wrap");

        tx_q = '{8'h92, 8'hAA, 8'h55, 8'h00};
        send_frame();
        wait_events(w);
        verify_regs("badcsum");
        chk("badcsum_code", {30'b0, o_err_code}, 2);
        chk("badcsum_cnt", {24'b0, o_err_cnt}, 1);

        tx_q = '{8'h12};
        send_frame();
        wait_events(w);
        chk("badhdr_code", {30'b0, o_err_code}, 1);
        tx_q = '{8'h81, 8'h3C, 8'hBD};
        send_frame();
        wait_events(w);
        verify_regs("after_badhdr");

        send_byte(8'h92);
        send_byte(8'hAA);
        exp_q.push_back(8'h03);
        wait_events(w);
        chk("tmo_not_early", {31'b0, w >= TMO - 5}, 1);
        chk("tmo_code", {30'b0, o_err_code}, 3);
        verify_regs("tmo");
        tx_q = '{8'hA4, 8'h11, 8'h22, 8'h33, 8'hA4};
        send_frame();
        wait_events(w);
        verify_regs("after_tmo");

        send_byte(8'h92);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h92 ^ 8'h77 ^ 8'h88);
        rst_n = 1'b0;
        #1;
        chk("midrst_ren", {31'b0, o_rx_ren}, 0);
        chk("midrst_ok", {31'b0, o_frame_ok}, 0);
        chk("midrst_err", {31'b0, o_frame_err}, 0);
        chk("midrst_code", {30'b0, o_err_code}, 0);
        chk("midrst_cnt", {24'b0, o_err_cnt}, 0);
        for (int i = 0; i < 16; i++) mdl_reg[i] = 8'h00;
        mdl_err_cnt = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        verify_regs("midrst");

        mon_en = 1'b0;
        ren_pairs = 0;
        ren_pulses = 0;
        @(negedge clk);
        i_rx_data = 8'h12;
        i_rx_rdy  = 1'b1;
        repeat (600) @(negedge clk);
        i_rx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("ren_back_to_back", 32'(ren_pairs), 0);
        chk("ren_pulses_min", {31'b0, ren_pulses >= 290}, 1);
        chk("err_cnt_sat", {24'b0, o_err_cnt}, 32'hFF);
        chk("sat_code", {30'b0, o_err_code}, 1);
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
